// File: rtl/enc_pkg.sv
// Shared definitions for the byte-stream encryption sequencer: FSM state
// encoding, command encodings, keystream polynomial and the default seed.
package enc_pkg;

    localparam int DATA_W = 8;
    localparam int LFSR_W = 16;

    localparam logic [LFSR_W-1:0] LFSR_POLY    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEY_LO = 3'd1,
        ST_KEY_HI = 3'd2,
        ST_RUN    = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_NOP      = 2'b00,
        CMD_LOAD_KEY = 2'b01,
        CMD_ENCRYPT  = 2'b10,
        CMD_ABORT    = 2'b11
    } cmd_t;

    // One Galois step: shift right, fold the polynomial in when a 1 drops out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ LFSR_POLY;
        end
        return r;
    endfunction

endpackage

// File: rtl/enc_lfsr8.sv
// Combinational keystream advance: eight Galois LFSR steps, i.e. one byte's
// worth of keystream consumed per call.
module enc_lfsr8
    import enc_pkg::*;
(
    input  logic [15:0] state_in,
    output logic [15:0] state_out
);

    // Unrolled chain of eight single-bit steps.
    always_comb begin
        state_out = state_in;
        for (int i = 0; i < 8; i++) begin
            state_out = lfsr_step(state_out);
        end
    end

endmodule

// File: rtl/enc_seq_ctrl.sv
// Command-driven sequencer for a 16-bit LFSR stream cipher. A two-byte seed
// is loaded via LOAD_KEY; ENCRYPT then XORs len input bytes with the
// keystream, one byte per cycle, through a single-entry output register.
module enc_seq_ctrl
    import enc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] cmd,
    input  logic       cmd_valid,
    input  logic [7:0] len,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy,
    output logic       key_loaded,
    output logic       err
);

    state_t      state;
    state_t      state_next;
    cmd_t        cmd_dec;

    logic [15:0] seed;
    logic [15:0] seed_next;
    logic [15:0] ks;
    logic [15:0] ks_next;
    logic [15:0] ks_adv;
    logic [15:0] key_word;
    logic [7:0]  count;
    logic [7:0]  count_next;
    logic [7:0]  dout_next;
    logic        dout_valid_next;
    logic        key_loaded_next;
    logic        err_next;

    logic        cmd_act;
    logic        abort;
    logic        din_hs;
    logic        out_hs;

    assign cmd_dec  = cmd_t'(cmd);
    assign cmd_act  = ena & cmd_valid;
    assign abort    = cmd_act & (cmd_dec == CMD_ABORT);
    assign din_hs   = din_valid & din_ready;
    assign out_hs   = dout_valid & dout_ready;
    assign busy     = (state != ST_IDLE);
    assign key_word = {din, seed[7:0]};

    enc_lfsr8 u_lfsr8 (
        .state_in  (ks),
        .state_out (ks_adv)
    );

    // Input acceptance: abort wins over a byte offered in the same cycle,
    // and in RUN a byte is only taken when the output register can accept it.
    always_comb begin
        din_ready = 1'b0;
        if (ena && !abort) begin
            case (state)
                ST_KEY_LO, ST_KEY_HI: din_ready = 1'b1;
                ST_RUN:               din_ready = !dout_valid || dout_ready;
                default:              din_ready = 1'b0;
            endcase
        end
    end

    // Next-state and next-register values for the whole controller.
    always_comb begin
        state_next      = state;
        seed_next       = seed;
        ks_next         = ks;
        count_next      = count;
        dout_next       = dout;
        dout_valid_next = dout_valid;
        key_loaded_next = key_loaded;
        err_next        = 1'b0;

        if (!ena) begin
            // Frozen: the error pulse is held along with everything else.
            err_next = err;
        end else if (abort) begin
            state_next      = ST_IDLE;
            dout_valid_next = 1'b0;
            count_next      = 8'd0;
            if (state == ST_KEY_LO || state == ST_KEY_HI) begin
                key_loaded_next = 1'b0;
            end
        end else begin
            if (cmd_act && state != ST_IDLE &&
                (cmd_dec == CMD_LOAD_KEY || cmd_dec == CMD_ENCRYPT)) begin
                err_next = 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_act && cmd_dec == CMD_LOAD_KEY) begin
                        key_loaded_next = 1'b0;
                        state_next      = ST_KEY_LO;
                    end else if (cmd_act && cmd_dec == CMD_ENCRYPT) begin
                        if (key_loaded && len != 8'd0) begin
                            count_next = len;
                            ks_next    = seed;
                            state_next = ST_RUN;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end

                ST_KEY_LO: begin
                    if (din_hs) begin
                        seed_next[7:0] = din;
                        state_next     = ST_KEY_HI;
                    end
                end

                ST_KEY_HI: begin
                    if (din_hs) begin
                        // An all-zero seed would lock the LFSR at zero.
                        seed_next       = (key_word == 16'h0000) ? DEFAULT_SEED : key_word;
                        key_loaded_next = 1'b1;
                        state_next      = ST_IDLE;
                    end
                end

                ST_RUN: begin
                    if (din_hs) begin
                        dout_next       = din ^ ks[7:0];
                        dout_valid_next = 1'b1;
                        ks_next         = ks_adv;
                        count_next      = count - 8'd1;
                        if (count == 8'd1) begin
                            state_next = ST_FLUSH;
                        end
                    end else if (out_hs) begin
                        dout_valid_next = 1'b0;
                    end
                end

                ST_FLUSH: begin
                    if (out_hs || !dout_valid) begin
                        dout_valid_next = 1'b0;
                        state_next      = ST_IDLE;
                    end
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Seed, keystream, byte counter, output register and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed       <= DEFAULT_SEED;
            ks         <= DEFAULT_SEED;
            count      <= 8'd0;
            dout       <= 8'd0;
            dout_valid <= 1'b0;
            key_loaded <= 1'b0;
            err        <= 1'b0;
        end else begin
            seed       <= seed_next;
            ks         <= ks_next;
            count      <= count_next;
            dout       <= dout_next;
            dout_valid <= dout_valid_next;
            key_loaded <= key_loaded_next;
            err        <= err_next;
        end
    end

endmodule

// File: doc/enc_seq_ctrl.md
ENC_SEQ_CTRL -- requirements
Module: enc_seq_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: ena  in  1  design enable; 0 freezes all state.
REQ-004 SHALL have ports: cmd  in  2  command (00 NOP, 01 LOAD_KEY, 10 ENCRYPT, 11 ABORT); cmd_valid  in  1  command strobe.
REQ-005 SHALL have port: len  in  8  byte count, sampled with ENCRYPT.
REQ-006 SHALL have ports: din  in  8  key/plaintext byte; din_valid  in  1; din_ready  out  1.
REQ-007 SHALL have ports: dout  out  8  ciphertext byte; dout_valid  out  1; dout_ready  in  1.
REQ-008 SHALL have ports: busy  out  1  state != IDLE; key_loaded  out  1  seed valid; err  out  1  one-cycle error pulse.

Function
REQ-009 SHALL implement FSM states IDLE, KEY_LO, KEY_HI, RUN, FLUSH.
REQ-010 SHALL, in IDLE on LOAD_KEY, clear key_loaded and go to KEY_LO.
REQ-011 SHALL, in KEY_LO/KEY_HI, assert din_ready and on din handshake store seed[7:0] / seed[15:8] respectively; after KEY_HI set key_loaded and return to IDLE.
REQ-012 SHALL replace stored seed 16'h0000 with 16'hACE1 (default seed).
REQ-013 SHALL, in IDLE on ENCRYPT with key_loaded=1 and len!=0, load count=len, load keystream state from stored seed, enter RUN.
REQ-014 SHALL, on ENCRYPT with key_loaded=0 or len=0, pulse err for one cycle and stay IDLE.
REQ-015 SHALL, in RUN, drive din_ready = ena & (!dout_valid | dout_ready) & !(cmd_valid & cmd==ABORT).
REQ-016 SHALL, on RUN din handshake at edge t, present dout = din XOR ks[7:0] with dout_valid=1 after edge t (latency 1), advance keystream 8 Galois steps, decrement count.
REQ-017 SHALL advance keystream per step: lsb=s[0]; s=s>>1; if lsb then s^=16'hB400.
REQ-018 SHALL sustain 1 byte/cycle when dout_ready held high.
REQ-019 SHALL hold dout and dout_valid stable until dout_ready handshake; clear dout_valid on handshake with no new byte.
REQ-020 SHALL enter FLUSH when count reaches 0; leave FLUSH to IDLE on the cycle dout_valid is cleared.
REQ-021 SHALL, on ABORT in any state, go to IDLE next edge, clear dout_valid and count; key_loaded cleared if abort from KEY_LO/KEY_HI, else preserved.
REQ-022 SHALL ignore LOAD_KEY/ENCRYPT outside IDLE and pulse err.
REQ-023 SHALL give ABORT priority over a simultaneous din handshake (byte not consumed).
REQ-024 SHALL, with ena=0, hold all registers, drive din_ready=0, ignore cmd_valid.
REQ-025 SHALL treat NOP as no action.

Reset
REQ-026 SHALL on rst_n=0 immediately force: state IDLE, dout=0, dout_valid=0, key_loaded=0, err=0, busy=0, din_ready=0, seed=16'hACE1, count=0.
REQ-027 SHALL abandon any in-progress key load or encryption on reset mid-operation; no residual output after release.

Structure
REQ-028 SHALL place state encoding, cmd encodings, polynomial 16'hB400, default seed 16'hACE1 in shared package enc_pkg.
REQ-029 SHALL implement the 8-step keystream next-state function as combinational sub-module enc_lfsr8 (16-bit in, 16-bit out).
REQ-030 SHALL be sized at 120-400 lines RTL total.

Verification
REQ-031 SHALL test: LOAD_KEY, din 0x34 then 0x12, ENCRYPT len=1, din 0x00 -> dout 0x34, dout_valid 1 cycle after accept, busy drops after handshake.
REQ-032 SHALL test: seed 0x0000 loaded, ENCRYPT len=1 din 0x00 -> dout 0xE1.
REQ-033 SHALL test: encrypt 4 bytes {0xDE,0xAD,0xBE,0xEF} with seed 0x1234, re-encrypt ciphertext with same seed -> plaintext returned; dout_ready high -> 4 outputs on 4 consecutive cycles.
REQ-034 SHALL test: ENCRYPT before any key load, and ENCRYPT len=0 -> err one-cycle pulse, busy stays 0.
REQ-035 SHALL test: ABORT concurrent with din handshake at byte 2 of 5 -> din_ready 0 that cycle, IDLE next edge, dout_valid 0, key_loaded remains 1.
REQ-036 SHALL test: dout_ready held 0 for 3 cycles mid-RUN -> dout stable, din_ready 0; rst_n low mid-RUN -> all outputs at reset values asynchronously.
